// File: rtl/riscv_branch_predictor_if.sv
// Fetch/Execute-side signal bundle of the branch predictor.
// master = pipeline side, slave = predictor.
interface riscv_branch_predictor_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
);
  logic [XLEN-1:0]   i_PCF;
  logic              o_pred_takenF;
  logic [XLEN-1:0]   o_pred_targetF;
  logic              i_update_enE;
  logic [XLEN-1:0]   i_PCE;
  logic              i_jumpE;
  logic              i_takenE;
  logic [XLEN-1:0]   i_targetE;
  logic              i_pred_takenE;
  logic [XLEN-1:0]   i_pred_targetE;
  logic              i_flush_table;
  logic              o_mispredictE;
  logic [STAT_W-1:0] o_branch_cnt;
  logic [STAT_W-1:0] o_mispred_cnt;

  modport master (
    output i_PCF, i_update_enE, i_PCE, i_jumpE, i_takenE, i_targetE,
           i_pred_takenE, i_pred_targetE, i_flush_table,
    input  o_pred_takenF, o_pred_targetF, o_mispredictE, o_branch_cnt, o_mispred_cnt
  );

  modport slave (
    input  i_PCF, i_update_enE, i_PCE, i_jumpE, i_takenE, i_targetE,
           i_pred_takenE, i_pred_targetE, i_flush_table,
    output o_pred_takenF, o_pred_targetF, o_mispredictE, o_branch_cnt, o_mispred_cnt
  );
endinterface

// File: rtl/riscv_branch_predictor.sv
// Direct-mapped tagged BTB with saturating direction counters, combinational
// fetch lookup, execute-time update and saturating branch/mispredict statistics.
module riscv_branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  riscv_branch_predictor_if.slave   bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int unsigned WT_I = 1 << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(WT_I);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(WT_I - 1);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0]  idx_f, idx_e;
  logic [TAG_W-1:0]  tag_f, tag_e;
  logic              hit_f, hit_e;
  logic              ent_we;
  logic [XLEN-1:0]   target_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              mispredict;

  // Only the index/tag fields of the PCs matter; the rest is deliberately ignored.
  logic unused_pc;
  assign unused_pc = ^{bp.i_PCF, bp.i_PCE};

  assign idx_f = bp.i_PCF[IDX_W+1:2];
  assign tag_f = bp.i_PCF[IDX_W+2 +: TAG_W];
  assign idx_e = bp.i_PCE[IDX_W+1:2];
  assign tag_e = bp.i_PCE[IDX_W+2 +: TAG_W];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  assign bp.o_pred_takenF  = hit_f & cnt_q[idx_f][CNT_W-1];
  assign bp.o_pred_targetF = bp.o_pred_takenF ? target_q[idx_f] : bp.i_PCF + XLEN'(4);

  assign mispredict = bp.i_update_enE &
                      ((bp.i_pred_takenE != bp.i_takenE) |
                       (bp.i_takenE & (bp.i_pred_targetE != bp.i_targetE)));
  assign bp.o_mispredictE = mispredict;
  assign bp.o_branch_cnt  = branch_cnt_q;
  assign bp.o_mispred_cnt = mispred_cnt_q;

  // New contents of the single entry addressed by the resolving PC.
  always_comb begin
    ent_we   = 1'b0;
    cnt_d    = cnt_q[idx_e];
    target_d = target_q[idx_e];
    if (bp.i_update_enE) begin
      if (hit_e) begin
        ent_we = 1'b1;
        if (bp.i_jumpE) begin
          cnt_d    = CNT_MAX;
          target_d = bp.i_targetE;
        end else if (bp.i_takenE) begin
          if (cnt_q[idx_e] != CNT_MAX) cnt_d = cnt_q[idx_e] + CNT_W'(1);
          target_d = bp.i_targetE;
        end else if (cnt_q[idx_e] != '0) begin
          cnt_d = cnt_q[idx_e] - CNT_W'(1);
        end
      end else if (bp.i_takenE) begin
        ent_we   = 1'b1;
        cnt_d    = bp.i_jumpE ? CNT_MAX : CNT_WT;
        target_d = bp.i_targetE;
      end
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bp.i_update_enE && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + STAT_W'(1);
    if (mispredict && (mispred_cnt_q != '1))     mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Flush wins over a same-cycle update; only valid bits are cleared.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (bp.i_flush_table) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (ent_we) begin
      valid_q[idx_e]  <= 1'b1;
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= target_d;
      cnt_q[idx_e]    <= cnt_d;
    end
  end
endmodule

// File: doc/riscv_branch_predictor.md
Name: riscv_branch_predictor

Overview:
- Parametrised dynamic branch predictor for the next-generation pipelined RV32I core: a direct-mapped table of tagged entries, each holding a branch target buffer (BTB) target and an N-bit saturating direction counter.
- Looked up combinationally in Fetch with the current PC; updated from Execute when a branch or jump resolves.
- Reports a mispredict flag to the hazard unit and keeps saturating branch/mispredict statistics.
- Replaces the static "predict not-taken, redirect from Execute" scheme.

Parameters:
- XLEN, 32, data/address width.
- ENTRIES, 64, number of table entries; power of two, >= 2; IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry; IDX_W+2+TAG_W <= XLEN.
- CNT_W, 2, direction counter width; >= 1.
- STAT_W, 32, statistics counter width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous reset, active-high
- i_PCF  in  XLEN  fetch PC
- o_pred_takenF  out  1  predicted taken for i_PCF
- o_pred_targetF  out  XLEN  predicted next PC for i_PCF
- i_update_enE  in  1  a branch/jump resolved in Execute this cycle
- i_PCE  in  XLEN  PC of the resolving instruction
- i_jumpE  in  1  resolving instruction is JAL/JALR (unconditional)
- i_takenE  in  1  actual outcome
- i_targetE  in  XLEN  actual target
- i_pred_takenE  in  1  prediction made for this instruction, piped from F
- i_pred_targetE  in  XLEN  predicted target, piped from F
- i_flush_table  in  1  synchronous invalidate of all entries
- o_mispredictE  out  1  redirect required
- o_branch_cnt  out  STAT_W  resolved branch/jump count
- o_mispred_cnt  out  STAT_W  mispredict count

Behaviour:
- Address fields: idx = PC[IDX_W+1:2]; tag = PC[IDX_W+2+TAG_W-1 : IDX_W+2]. PC[1:0] is ignored.
- Entry contents: valid, tag[TAG_W], target[XLEN], cnt[CNT_W]. Table is register-based.
- Reset state (i_rst=1, asynchronous):
  - All valid = 0; all cnt = WNT = 2^(CNT_W-1)-1, i.e. 01 for CNT_W=2; tags and targets = 0.
  - Both statistics counters = 0.
  - Consequently o_pred_takenF=0 and o_pred_targetF=i_PCF+4.
- Lookup (combinational, zero latency):
  - hitF = valid[idxF] & (tag[idxF]==tagF).
  - o_pred_takenF = hitF & cnt[idxF][CNT_W-1].
  - o_pred_targetF = o_pred_takenF ? target[idxF] : i_PCF+4, computed modulo 2^XLEN.
- Mispredict (combinational): o_mispredictE = i_update_enE & ((i_pred_takenE != i_takenE) | (i_takenE & (i_pred_targetE != i_targetE))).
- Update on the rising edge when i_update_enE=1, using idxE/tagE from i_PCE:
  - Hit, not jump: cnt saturating +1 if taken (capped at 2^CNT_W-1), saturating -1 if not taken (floored at 0). If taken, target <= i_targetE.
  - Hit, jump: cnt <= max; target <= i_targetE.
  - Miss, taken: allocate (overwriting any occupant). valid<=1, tag<=tagE, target<=i_targetE, cnt <= i_jumpE ? max : WT, where WT = 2^(CNT_W-1).
  - Miss, not taken: no table change.
- Same-cycle read/write: a lookup at the index being updated returns the pre-update contents. The new contents are visible from the next cycle.
- i_flush_table=1 at an edge: all valid <= 0; counters and statistics are unchanged. A flush has priority over a simultaneous update, so the update is dropped, but its statistics are still counted.
- Statistics:
  - o_branch_cnt increments on each i_update_enE.
  - o_mispred_cnt increments on each o_mispredictE.
  - Both saturate at 2^STAT_W-1 and never wrap.
- Reset asserted mid-operation clears everything immediately. The first update after reset release is processed normally.
- i_update_enE=0 means no state change. The i_*E inputs are don't-care in that case.

Test Plan:
- Reset then lookup: i_PCF=0x100 -> o_pred_takenF=0, o_pred_targetF=0x104; both statistics counters 0.
- Allocate: update PCE=0x100, taken, target 0x80, pred_taken=0. Expect o_mispredictE=1 that cycle. Next cycle i_PCF=0x100 -> taken=1, target=0x80; mispred_cnt=1, branch_cnt=1.
- Hysteresis (CNT_W=2):
  - From WT, one not-taken update -> cnt=01, predicts not-taken.
  - From strong-taken (11), one not-taken update -> cnt=10, still predicts taken, target 0x80.
  - Counter saturates at 11 after repeated taken updates.
- Aliasing/tag: ENTRIES=64. Allocate 0x100, then look up 0x200 (same idx, different tag) -> not taken, target 0x204. A taken update at 0x200 replaces the entry, so 0x100 then misses.
- Target mismatch: hit entry predicted taken to 0x80, resolves taken to 0x90 -> o_mispredictE=1; next lookup gives 0x90. A JAL miss allocates with cnt=11.
- Flush/reset/saturation:
  - i_flush_table together with an update -> all lookups miss, branch_cnt still increments.
  - STAT_W=4: 20 mispredicts -> o_mispred_cnt=15.
  - i_rst pulse mid-stream -> counters 0 and all lookups miss.
